// File: rtl/lieat_wbu.sv
// ============================================================================
// Module   : lieat_wbu
// Brief    : Writeback unit arbitrating EXU and long-instruction results into
//            a single regfile port; tracks long instructions in an in-order
//            FIFO and flags dispatch dependencies.
//            Optional macro LIEAT_WBU_OUTREG_EN registers all wb_* outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX
`define REG_IDX 5
`endif

module lieat_wbu #(
  parameter int LONGI_DEPTH = 4,
  parameter int LONGI_PTR   = $clog2(LONGI_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  disp_longi_valid,
  output logic                  disp_longi_ready,
  input  logic [`REG_IDX-1:0]   disp_longi_rd,
  input  logic [`XLEN-1:0]      disp_longi_pc,
  input  logic                  disp_longi_lsu,
  output logic [LONGI_PTR-1:0]  disp_longi_tag,
  input  logic [`REG_IDX-1:0]   chk_rs1,
  input  logic [`REG_IDX-1:0]   chk_rs2,
  input  logic [`REG_IDX-1:0]   chk_rd,
  output logic                  chk_dep,
  input  logic                  exu_wb_valid,
  output logic                  exu_wb_ready,
  input  logic                  exu_wb_en,
  input  logic [`REG_IDX-1:0]   exu_wb_rd,
  input  logic [`XLEN-1:0]      exu_wb_data,
  input  logic [`XLEN-1:0]      exu_wb_pc,
  input  logic                  exu_wb_ebreak,
  input  logic                  long_wb_valid,
  output logic                  long_wb_ready,
  input  logic [LONGI_PTR-1:0]  long_wb_tag,
  input  logic [`XLEN-1:0]      long_wb_data,
  output logic                  wb_valid,
  output logic                  wb_en,
  output logic [`REG_IDX-1:0]   wb_rd,
  output logic [`XLEN-1:0]      wb_data,
  output logic [`XLEN-1:0]      wb_pc,
  output logic                  wb_lsu,
  output logic                  wb_ebreak,
  output logic                  longi_empty,
  output logic                  wb_tag_err
);

  localparam int c_XW = `XLEN;
  localparam int c_RW = `REG_IDX;
  localparam logic [LONGI_PTR:0] c_PTR_ONE = {{LONGI_PTR{1'b0}}, 1'b1};

  logic [c_RW-1:0]        r_ent_rd  [LONGI_DEPTH];
  logic [c_XW-1:0]        r_ent_pc  [LONGI_DEPTH];
  logic [LONGI_DEPTH-1:0] r_ent_lsu;
  logic [LONGI_DEPTH-1:0] r_ent_vld;
  logic [LONGI_PTR:0]     r_head;
  logic [LONGI_PTR:0]     r_tail;
  logic                   r_tag_err;

  logic [LONGI_PTR-1:0]   w_head_idx;
  logic [LONGI_PTR-1:0]   w_tail_idx;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_alloc;
  logic                   w_long_ret;
  logic                   w_exu_ret;
  logic [LONGI_DEPTH-1:0] w_dep_hit;
  logic                   w_pend_hit;

  logic                   w_wb_valid;
  logic                   w_wb_en;
  logic [c_RW-1:0]        w_wb_rd;
  logic [c_XW-1:0]        w_wb_data;
  logic [c_XW-1:0]        w_wb_pc;
  logic                   w_wb_lsu;
  logic                   w_wb_ebreak;

  assign w_head_idx = r_head[LONGI_PTR-1:0];
  assign w_tail_idx = r_tail[LONGI_PTR-1:0];
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (r_head[LONGI_PTR] != r_tail[LONGI_PTR]) && (w_head_idx == w_tail_idx);

  // Full is judged on pre-retire state, so a same-cycle retire never frees a slot.
  assign w_alloc    = disp_longi_valid & ~w_full;
  assign w_long_ret = long_wb_valid & ~w_empty;
  assign w_exu_ret  = exu_wb_valid & ~w_long_ret;

  assign disp_longi_ready = ~w_full;
  assign disp_longi_tag   = w_tail_idx;
  assign long_wb_ready    = ~w_empty;
  assign exu_wb_ready     = ~w_long_ret;
  assign longi_empty      = w_empty;
  assign wb_tag_err       = r_tag_err;

  always_comb begin
    w_wb_valid  = 1'b0;
    w_wb_en     = 1'b0;
    w_wb_rd     = '0;
    w_wb_data   = '0;
    w_wb_pc     = '0;
    w_wb_lsu    = 1'b0;
    w_wb_ebreak = 1'b0;
    if (w_long_ret) begin
      w_wb_valid = 1'b1;
      w_wb_en    = (r_ent_rd[w_head_idx] != '0);
      w_wb_rd    = r_ent_rd[w_head_idx];
      w_wb_data  = long_wb_data;
      w_wb_pc    = r_ent_pc[w_head_idx];
      w_wb_lsu   = r_ent_lsu[w_head_idx];
    end else if (w_exu_ret) begin
      w_wb_valid  = 1'b1;
      w_wb_en     = exu_wb_en & (exu_wb_rd != '0);
      w_wb_rd     = exu_wb_rd;
      w_wb_data   = exu_wb_data;
      w_wb_pc     = exu_wb_pc;
      w_wb_ebreak = exu_wb_ebreak;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_ent_vld <= '0;
      r_tag_err <= 1'b0;
    end else begin
      if (w_long_ret) begin
        r_ent_vld[w_head_idx] <= 1'b0;
        r_head                <= r_head + c_PTR_ONE;
        if (long_wb_tag != w_head_idx)
          r_tag_err <= 1'b1;
      end
      if (w_alloc) begin
        r_ent_rd[w_tail_idx]  <= disp_longi_rd;
        r_ent_pc[w_tail_idx]  <= disp_longi_pc;
        r_ent_lsu[w_tail_idx] <= disp_longi_lsu;
        r_ent_vld[w_tail_idx] <= 1'b1;
        r_tail                <= r_tail + c_PTR_ONE;
      end
    end
  end

  generate
    for (genvar i = 0; i < LONGI_DEPTH; i++) begin : g_dep
      assign w_dep_hit[i] = r_ent_vld[i] && (r_ent_rd[i] != '0) &&
                            ((r_ent_rd[i] == chk_rs1) || (r_ent_rd[i] == chk_rs2) ||
                             (r_ent_rd[i] == chk_rd));
    end
  endgenerate

`ifdef LIEAT_WBU_OUTREG_EN
  logic              r_wb_valid;
  logic              r_wb_en;
  logic [c_RW-1:0]   r_wb_rd;
  logic [c_XW-1:0]   r_wb_data;
  logic [c_XW-1:0]   r_wb_pc;
  logic              r_wb_lsu;
  logic              r_wb_ebreak;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wb_valid  <= 1'b0;
      r_wb_en     <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_wb_pc     <= '0;
      r_wb_lsu    <= 1'b0;
      r_wb_ebreak <= 1'b0;
    end else begin
      r_wb_valid  <= w_wb_valid;
      r_wb_en     <= w_wb_en;
      r_wb_rd     <= w_wb_rd;
      r_wb_data   <= w_wb_data;
      r_wb_pc     <= w_wb_pc;
      r_wb_lsu    <= w_wb_lsu;
      r_wb_ebreak <= w_wb_ebreak;
    end
  end

  // The registered write is still in flight, so it counts as a hazard too.
  assign w_pend_hit = r_wb_en &&
                      ((r_wb_rd == chk_rs1) || (r_wb_rd == chk_rs2) || (r_wb_rd == chk_rd));

  assign wb_valid  = r_wb_valid;
  assign wb_en     = r_wb_en;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign wb_pc     = r_wb_pc;
  assign wb_lsu    = r_wb_lsu;
  assign wb_ebreak = r_wb_ebreak;
`else
  assign w_pend_hit = 1'b0;

  assign wb_valid  = w_wb_valid;
  assign wb_en     = w_wb_en;
  assign wb_rd     = w_wb_rd;
  assign wb_data   = w_wb_data;
  assign wb_pc     = w_wb_pc;
  assign wb_lsu    = w_wb_lsu;
  assign wb_ebreak = w_wb_ebreak;
`endif

  assign chk_dep = (|w_dep_hit) | w_pend_hit;

endmodule

`default_nettype wire

// File: tb/tb_lieat_wbu.sv
// ============================================================================
// Module   : tb_lieat_wbu
// Brief    : Self-checking bench for lieat_wbu (combinational output build),
//            directed steps followed by randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX
`define REG_IDX 5
`endif

module tb_lieat_wbu;

  localparam int DEPTH = 4;
  localparam int PTRW  = 2;

  typedef struct packed {
    logic [`REG_IDX-1:0] rd;
    logic [`XLEN-1:0]    pc;
    logic                lsu;
  } ent_t;

  logic                 clock;
  logic                 reset;
  logic                 disp_longi_valid;
  logic                 disp_longi_ready;
  logic [`REG_IDX-1:0]  disp_longi_rd;
  logic [`XLEN-1:0]     disp_longi_pc;
  logic                 disp_longi_lsu;
  logic [PTRW-1:0]      disp_longi_tag;
  logic [`REG_IDX-1:0]  chk_rs1, chk_rs2, chk_rd;
  logic                 chk_dep;
  logic                 exu_wb_valid, exu_wb_ready, exu_wb_en, exu_wb_ebreak;
  logic [`REG_IDX-1:0]  exu_wb_rd;
  logic [`XLEN-1:0]     exu_wb_data, exu_wb_pc;
  logic                 long_wb_valid, long_wb_ready;
  logic [PTRW-1:0]      long_wb_tag;
  logic [`XLEN-1:0]     long_wb_data;
  logic                 wb_valid, wb_en, wb_lsu, wb_ebreak;
  logic [`REG_IDX-1:0]  wb_rd;
  logic [`XLEN-1:0]     wb_data, wb_pc;
  logic                 longi_empty, wb_tag_err;

  int   checks    = 0;
  int   failures  = 0;
  ent_t q[$];
  int   alloc_cnt = 0;
  int   ret_cnt   = 0;
  bit   m_err     = 0;

  lieat_wbu #(.LONGI_DEPTH(DEPTH), .LONGI_PTR(PTRW)) dut (
    .clock(clock), .reset(reset),
    .disp_longi_valid(disp_longi_valid), .disp_longi_ready(disp_longi_ready),
    .disp_longi_rd(disp_longi_rd), .disp_longi_pc(disp_longi_pc),
    .disp_longi_lsu(disp_longi_lsu), .disp_longi_tag(disp_longi_tag),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .chk_dep(chk_dep),
    .exu_wb_valid(exu_wb_valid), .exu_wb_ready(exu_wb_ready), .exu_wb_en(exu_wb_en),
    .exu_wb_rd(exu_wb_rd), .exu_wb_data(exu_wb_data), .exu_wb_pc(exu_wb_pc),
    .exu_wb_ebreak(exu_wb_ebreak),
    .long_wb_valid(long_wb_valid), .long_wb_ready(long_wb_ready),
    .long_wb_tag(long_wb_tag), .long_wb_data(long_wb_data),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_pc(wb_pc), .wb_lsu(wb_lsu), .wb_ebreak(wb_ebreak),
    .longi_empty(longi_empty), .wb_tag_err(wb_tag_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    disp_longi_valid = 0; disp_longi_rd = '0; disp_longi_pc = '0; disp_longi_lsu = 0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    exu_wb_valid = 0; exu_wb_en = 0; exu_wb_rd = '0; exu_wb_data = '0;
    exu_wb_pc = '0; exu_wb_ebreak = 0;
    long_wb_valid = 0; long_wb_tag = '0; long_wb_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    q.delete();
    alloc_cnt = 0;
    ret_cnt   = 0;
    m_err     = 0;
  endtask

  // Checks every output against the queue model, then advances one clock.
  task automatic cycle();
    bit   empty, full, lret, eret, dep;
    ent_t e;
    #2;
    empty = (q.size() == 0);
    full  = (q.size() == DEPTH);
    lret  = long_wb_valid && !empty;
    eret  = exu_wb_valid && !lret;
    dep   = 0;
    foreach (q[i])
      if (q[i].rd != 0 && (q[i].rd == chk_rs1 || q[i].rd == chk_rs2 || q[i].rd == chk_rd))
        dep = 1;
    check("disp_ready", 64'(disp_longi_ready), 64'(!full));
    check("disp_tag", 64'(disp_longi_tag), 64'(alloc_cnt % DEPTH));
    check("long_ready", 64'(long_wb_ready), 64'(!empty));
    check("exu_ready", 64'(exu_wb_ready), 64'(!lret));
    check("longi_empty", 64'(longi_empty), 64'(empty));
    check("tag_err", 64'(wb_tag_err), 64'(m_err));
    check("chk_dep", 64'(chk_dep), 64'(dep));
    check("wb_valid", 64'(wb_valid), 64'(lret || eret));
    if (lret) begin
      check("long_en", 64'(wb_en), 64'(q[0].rd != 0));
      check("long_rd", 64'(wb_rd), 64'(q[0].rd));
      check("long_data", 64'(wb_data), 64'(long_wb_data));
      check("long_pc", 64'(wb_pc), 64'(q[0].pc));
      check("long_lsu", 64'(wb_lsu), 64'(q[0].lsu));
      check("long_ebreak", 64'(wb_ebreak), 64'(1'b0));
    end else if (eret) begin
      check("exu_en", 64'(wb_en), 64'(exu_wb_en && exu_wb_rd != 0));
      check("exu_rd", 64'(wb_rd), 64'(exu_wb_rd));
      check("exu_data", 64'(wb_data), 64'(exu_wb_data));
      check("exu_pc", 64'(wb_pc), 64'(exu_wb_pc));
      check("exu_lsu", 64'(wb_lsu), 64'(1'b0));
      check("exu_ebreak", 64'(wb_ebreak), 64'(exu_wb_ebreak));
    end else begin
      check("idle_en", 64'(wb_en), 64'(1'b0));
    end
    @(posedge clock);
    if (lret) begin
      if (int'(long_wb_tag) != ret_cnt % DEPTH) m_err = 1;
      void'(q.pop_front());
      ret_cnt++;
    end
    if (disp_longi_valid && !full) begin
      e.rd = disp_longi_rd; e.pc = disp_longi_pc; e.lsu = disp_longi_lsu;
      q.push_back(e);
      alloc_cnt++;
    end
    #1;
  endtask

  initial begin
    // 1: reset and idle
    do_reset();
    cycle();
    check("t1_ready", 64'(disp_longi_ready), 64'(1'b1));
    check("t1_empty", 64'(longi_empty), 64'(1'b1));

    // 2: EXU retire, then rd=0 variant
    exu_wb_valid = 1; exu_wb_en = 1; exu_wb_rd = 5'd5;
    exu_wb_data = 32'h1234; exu_wb_pc = 32'h8000_0000;
    #1 check("t2_data", 64'(wb_data), 64'h1234);
    check("t2_en", 64'(wb_en), 64'(1'b1));
    cycle();
    exu_wb_rd = 5'd0;
    #1 check("t2_rd0_en", 64'(wb_en), 64'(1'b0));
    cycle();
    idle();

    // 3: fill the FIFO, refuse a 5th, retire in order
    for (int i = 0; i < 4; i++) begin
      disp_longi_valid = 1; disp_longi_rd = 5'(i + 1);
      disp_longi_pc = 32'h100 + 32'(4 * i); disp_longi_lsu = i[0];
      cycle();
    end
    disp_longi_rd = 5'd9;
    #1 check("t3_full", 64'(disp_longi_ready), 64'(1'b0));
    cycle();
    disp_longi_valid = 0;
    for (int i = 0; i < 4; i++) begin
      long_wb_valid = 1; long_wb_tag = PTRW'(i); long_wb_data = 32'hA0 + 32'(i);
      #1 check("t3_rd", 64'(wb_rd), 64'(i + 1));
      check("t3_lsu", 64'(wb_lsu), 64'(i % 2));
      cycle();
    end
    idle();
    #1 check("t3_empty", 64'(longi_empty), 64'(1'b1));
    cycle();

    // 4: simultaneous EXU and long retire
    disp_longi_valid = 1; disp_longi_rd = 5'd3; disp_longi_pc = 32'h200;
    cycle();
    idle();
    exu_wb_valid = 1; exu_wb_en = 1; exu_wb_rd = 5'd6; exu_wb_data = 32'h55; exu_wb_pc = 32'h300;
    long_wb_valid = 1; long_wb_tag = 2'd0; long_wb_data = 32'h77;
    #1 check("t4_exu_ready", 64'(exu_wb_ready), 64'(1'b0));
    check("t4_long_data", 64'(wb_data), 64'h77);
    cycle();
    long_wb_valid = 0;
    #1 check("t4_exu_data", 64'(wb_data), 64'h55);
    cycle();
    idle();

    // 5: dependency checks
    disp_longi_valid = 1; disp_longi_rd = 5'd7; disp_longi_pc = 32'h400;
    cycle();
    disp_longi_rd = 5'd0; disp_longi_pc = 32'h404;
    cycle();
    disp_longi_valid = 0; chk_rs2 = 5'd7;
    #1 check("t5_dep7", 64'(chk_dep), 64'(1'b1));
    cycle();
    chk_rs2 = 5'd0;
    #1 check("t5_dep0", 64'(chk_dep), 64'(1'b0));
    cycle();
    long_wb_valid = 1; long_wb_tag = 2'd1; long_wb_data = 32'h11;
    cycle();
    long_wb_valid = 0; chk_rs2 = 5'd7;
    #1 check("t5_dep_after", 64'(chk_dep), 64'(1'b0));
    cycle();
    long_wb_valid = 1; long_wb_tag = 2'd2; chk_rs2 = 5'd0;
    cycle();
    idle();

    // 6: tag mismatch is sticky until reset
    do_reset();
    disp_longi_valid = 1; disp_longi_rd = 5'd9; disp_longi_pc = 32'h500; disp_longi_lsu = 1;
    cycle();
    idle();
    long_wb_valid = 1; long_wb_tag = 2'd2; long_wb_data = 32'hBEEF;
    #1 check("t6_rd", 64'(wb_rd), 64'd9);
    cycle();
    idle();
    #1 check("t6_err", 64'(wb_tag_err), 64'(1'b1));
    repeat (3) cycle();
    check("t6_err_sticky", 64'(wb_tag_err), 64'(1'b1));
    do_reset();
    #1 check("t6_err_clr", 64'(wb_tag_err), 64'(1'b0));
    cycle();

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      disp_longi_valid = 1'($urandom_range(0, 1));
      disp_longi_rd    = 5'($urandom_range(0, 7));
      disp_longi_pc    = $urandom;
      disp_longi_lsu   = 1'($urandom_range(0, 1));
      chk_rs1          = 5'($urandom_range(0, 7));
      chk_rs2          = 5'($urandom_range(0, 7));
      chk_rd           = 5'($urandom_range(0, 7));
      exu_wb_valid     = 1'($urandom_range(0, 1));
      exu_wb_en        = 1'($urandom_range(0, 1));
      exu_wb_rd        = 5'($urandom_range(0, 31));
      exu_wb_data      = $urandom;
      exu_wb_pc        = $urandom;
      exu_wb_ebreak    = ($urandom_range(0, 7) == 0);
      long_wb_valid    = ($urandom_range(0, 2) != 0);
      long_wb_tag      = ($urandom_range(0, 31) == 0) ? PTRW'(ret_cnt + 1) : PTRW'(ret_cnt);
      long_wb_data     = $urandom;
      cycle();
    end
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lieat_wbu.md
Name: lieat_wbu

Overview:
Writeback unit sitting directly upstream of the register file. It arbitrates between in-order EXU results and out-of-band long-instruction results (LSU loads, multi-cycle ops) and drives a single writeback port into the regfile. It tracks outstanding long instructions in a small in-order FIFO (the longi FIFO), and it provides dependency checks to dispatch.

Parameters:
- LONGI_DEPTH, 4: longi FIFO entries; must be a power of two, minimum 2.
- LONGI_PTR, log2(LONGI_DEPTH): tag width. Pointers carry one extra wrap bit internally.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- disp_longi_valid  in  1  dispatch allocates a long-instruction entry
- disp_longi_ready  out  1  allocation accepted (FIFO not full)
- disp_longi_rd  in  `REG_IDX  destination register of the long instruction
- disp_longi_pc  in  `XLEN  PC of the long instruction
- disp_longi_lsu  in  1  long instruction is a load/store
- disp_longi_tag  out  LONGI_PTR  index of the allocated entry (tail pointer)
- chk_rs1, chk_rs2, chk_rd  in  `REG_IDX  dispatch operand indices
- chk_dep  out  1  a valid entry's rd (nonzero) matches any nonzero chk_* index
- exu_wb_valid  in  1  EXU result available
- exu_wb_ready  out  1  EXU result consumed this cycle
- exu_wb_en  in  1  EXU result writes rd
- exu_wb_rd  in  `REG_IDX  EXU destination register
- exu_wb_data  in  `XLEN  EXU result
- exu_wb_pc  in  `XLEN  EXU instruction PC
- exu_wb_ebreak  in  1  instruction is ebreak
- long_wb_valid  in  1  long-instruction result available
- long_wb_ready  out  1  long result consumed this cycle
- long_wb_tag  in  LONGI_PTR  entry the result belongs to
- long_wb_data  in  `XLEN  long result
- wb_valid  out  1  one instruction retires
- wb_en  out  1  regfile write enable
- wb_rd  out  `REG_IDX  write index
- wb_data  out  `XLEN  write data
- wb_pc  out  `XLEN  retiring PC
- wb_lsu  out  1  retiring instruction is a long LSU op
- wb_ebreak  out  1  retiring instruction is ebreak
- longi_empty  out  1  no outstanding long instructions
- wb_tag_err  out  1  sticky flag: long_wb_tag did not match the head pointer

Behaviour:
- **Reset.**
  - Head and tail pointers cleared; all entry valid bits cleared.
  - wb_tag_err cleared.
  - All wb_* outputs 0; longi_empty 1; disp_longi_ready 1.
- **Allocation.**
  - disp_longi_ready = ~full.
  - An allocation occurs when valid & ready. The entry is written with {rd, pc, lsu}, valid is set, and tail increments modulo 2·LONGI_DEPTH.
  - Allocation is blocked when full, even if a retire happens in the same cycle (no pass-through).
- **Pointer states.**
  - full: pointers differ only in the wrap bit.
  - empty: pointers are equal.
  - longi_empty = empty, taken from registered state (not updated until the cycle after a retire).
- **Long retire.**
  - long_wb_ready = ~empty. long_wb_valid while empty is ignored.
  - Retire occurs when long_wb_valid & ~empty, and always completes in that cycle.
  - Long retires have priority over EXU.
  - Outputs: wb_valid=1; wb_rd, wb_pc and wb_lsu come from the head entry; wb_data = long_wb_data; wb_en = (head rd != 0); wb_ebreak = 0.
  - The head entry's valid bit is cleared and head increments.
  - If long_wb_tag != head index, wb_tag_err sets and stays set until reset; the retire still proceeds.
- **EXU retire.**
  - exu_wb_ready = ~(long_wb_valid & ~empty).
  - When valid & ready: wb_valid=1 and wb_en = exu_wb_en & (exu_wb_rd != 0). The remaining outputs pass from exu_*; wb_lsu=0.
  - When nothing retires, wb_valid=0 and wb_en=0. Data/rd/pc hold don't-care but stable values.
- **Simultaneous events.**
  - Allocation and long retire in the same cycle are both performed.
  - A chk_dep lookup in the same cycle as a retire sees pre-retire state (conservative).
- **Dependency check.**
  - chk_dep is combinational over valid entries.
  - Index 0 never matches.
- **Latency.** Combinational pass-through (0 cycles) from retire inputs to wb_* when the optional feature is off.

Optional Feature:
Macro LIEAT_WBU_OUTREG_EN.
- Defined: all wb_* outputs are registered, giving a 1-cycle latency from the retire handshake to the regfile write. Output regs reset to 0.
  - Retire handshakes, pointer updates and longi_empty are unchanged.
  - chk_dep also matches a pending registered wb_rd when wb_en=1, covering the extra in-flight write.
- Undefined: combinational outputs, as described in Behaviour.

Test Plan:
1. Reset, then idle → wb_valid=0, longi_empty=1, disp_longi_ready=1, wb_tag_err=0.
2. EXU retire rd=5, data=0x1234, pc=0x80000000, en=1 → same cycle wb_valid=1, wb_en=1, wb_rd=5, wb_data=0x1234; rd=0 variant → wb_en=0.
3. Allocate 4 entries (rd=1..4) → disp_longi_ready=0 after the 4th and a 5th allocation is refused; retire tags 0..3 with data 0xA0..0xA3 → wb_rd=1..4 in order, wb_lsu reflects each entry's lsu bit, longi_empty=1 the cycle after the last retire.
4. EXU valid and long valid in the same cycle → long retires, exu_wb_ready=0; EXU retires the next cycle with its data unchanged.
5. One entry outstanding with rd=7; chk_rs2=7 → chk_dep=1; chk_rs1=0 against a rd=0 entry → chk_dep=0; after retire → chk_dep=0.
6. Long retire with long_wb_tag=2 while head=0 → write proceeds from the head entry, wb_tag_err=1 and stays set until reset.
